// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector execute datapath: op encoding,
// lane slicing and signed saturation bounds.
package vec_pkg;

  localparam int VEC_OP_W   = 4;
  localparam int MAX_VEC_W  = 512;  // widest vector the slice helper handles
  localparam int MAX_LANE_W = 64;   // widest lane the helpers handle

  typedef enum logic [VEC_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_ADDS = 4'd8,
    OP_SUBS = 4'd9,
    OP_MIN  = 4'd10,
    OP_MAX  = 4'd11,
    OP_MUL  = 4'd12
  } vec_op_t;

  // All-ones mask covering the low lane_w bits.
  function automatic logic [MAX_LANE_W-1:0] lane_mask(input int unsigned lane_w);
    return (MAX_LANE_W'(1) << lane_w) - MAX_LANE_W'(1);
  endfunction

  // Extract lane 'lane' of a flattened vector; lane i sits at [i*lane_w +: lane_w].
  function automatic logic [MAX_LANE_W-1:0] lane_slice(input logic [MAX_VEC_W-1:0] vec,
                                                       input int unsigned lane,
                                                       input int unsigned lane_w);
    return MAX_LANE_W'(vec >> (lane * lane_w)) & lane_mask(lane_w);
  endfunction

  // Largest signed lane value, 2^(w-1)-1, as a zero-extended bit pattern.
  function automatic logic [MAX_LANE_W-1:0] sat_max(input int unsigned lane_w);
    return (MAX_LANE_W'(1) << (lane_w - 1)) - MAX_LANE_W'(1);
  endfunction

  // Smallest signed lane value, -2^(w-1), as a w-bit pattern zero-extended.
  function automatic logic [MAX_LANE_W-1:0] sat_min(input int unsigned lane_w);
    return MAX_LANE_W'(1) << (lane_w - 1);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU. Produces every non-multiply result directly
// and splits the multiply into partial products that the parent registers;
// the parent finishes the multiply one stage later.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int LANE_W = 16
) (
  input  logic [VEC_OP_W-1:0]              op_i,
  input  logic [LANE_W-1:0]                a_i,
  input  logic [LANE_W-1:0]                b_i,
  output logic [LANE_W-1:0]                res_o,
  output logic [LANE_W-1:0]                pp_ll_o,  // a_lo * b_lo
  output logic [LANE_W-(LANE_W/2)-1:0]     pp_x_o    // (a_lo*b_hi + a_hi*b_lo) mod 2^HI_W
);

  localparam int LO_W = LANE_W / 2;
  localparam int HI_W = LANE_W - LO_W;
  localparam int SH_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  logic [SH_W-1:0]   shamt;
  logic [LANE_W:0]   sum_ext;
  logic [LANE_W:0]   dif_ext;
  logic              a_lt_b;
  logic [LO_W-1:0]   a_lo;
  logic [LO_W-1:0]   b_lo;
  logic [HI_W-1:0]   a_hi;
  logic [HI_W-1:0]   b_hi;
  logic [2*LO_W-1:0] ll_prod;

  assign shamt  = b_i[SH_W-1:0];
  // One extra sign bit: the top two bits disagree exactly on signed overflow.
  assign sum_ext = {a_i[LANE_W-1], a_i} + {b_i[LANE_W-1], b_i};
  assign dif_ext = {a_i[LANE_W-1], a_i} - {b_i[LANE_W-1], b_i};
  assign a_lt_b  = $signed(a_i) < $signed(b_i);

  assign a_lo = a_i[LO_W-1:0];
  assign b_lo = b_i[LO_W-1:0];
  assign a_hi = a_i[LANE_W-1:LO_W];
  assign b_hi = b_i[LANE_W-1:LO_W];

  // Only the low LANE_W bits of the product survive, so the hi*hi term
  // vanishes and the cross term is needed only modulo 2^HI_W.
  assign ll_prod = a_lo * b_lo;
  assign pp_ll_o = LANE_W'(ll_prod);
  assign pp_x_o  = HI_W'(a_lo) * b_hi + a_hi * HI_W'(b_lo);

  // Lane result mux; MUL and undefined codes yield zero here.
  always_comb begin
    // NOTE: res_o is given a value before the case so every path assigns it and no latch is inferred.
    res_o = '0;
    case (vec_op_t'(op_i))
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SLL:  res_o = a_i << shamt;
      OP_SRL:  res_o = a_i >> shamt;
      OP_SRA:  res_o = $signed(a_i) >>> shamt;
      OP_ADDS: begin
        if (sum_ext[LANE_W] != sum_ext[LANE_W-1])
          res_o = sum_ext[LANE_W] ? LANE_W'(sat_min(LANE_W)) : LANE_W'(sat_max(LANE_W));
        else
          res_o = sum_ext[LANE_W-1:0];
      end
      OP_SUBS: begin
        if (dif_ext[LANE_W] != dif_ext[LANE_W-1])
          res_o = dif_ext[LANE_W] ? LANE_W'(sat_min(LANE_W)) : LANE_W'(sat_max(LANE_W));
        else
          res_o = dif_ext[LANE_W-1:0];
      end
      OP_MIN:  res_o = a_lt_b ? a_i : b_i;
      OP_MAX:  res_o = a_lt_b ? b_i : a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_pipe.sv
// Two-stage vector execute stage with valid/ready handshake, backpressure and
// flush. S1 captures per-lane ALU results and multiply partial products; S2
// finishes the multiply, selects the final lane values and computes the zero
// flags. All outputs come straight from S2 registers.
module vec_exec_pipe
  import vec_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int LANE_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VEC_OP_W-1:0]       in_op,
  input  logic [LANES*LANE_W-1:0]   in_src_a,
  input  logic [LANES*LANE_W-1:0]   in_src_b,
  input  logic [LANE_W-1:0]         in_scalar,
  input  logic                      in_bcast,
  input  logic [TAG_W-1:0]          in_rd,
  input  logic                      in_we,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_result,
  output logic [LANES-1:0]          out_zero,
  output logic [TAG_W-1:0]          out_rd,
  output logic                      out_we
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int LO_W  = LANE_W / 2;
  localparam int HI_W  = LANE_W - LO_W;

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
  typedef logic [LANES-1:0][HI_W-1:0]   lanes_hi_t;

  // Input-side datapath
  logic [VEC_W-1:0] src_b_sel;
  lanes_t           lane_a;
  lanes_t           lane_b;
  lanes_t           alu_res;
  lanes_t           alu_pp_ll;
  lanes_hi_t        alu_pp_x;

  // S1 registers
  logic                s1_valid_q, s1_valid_d;
  logic [VEC_OP_W-1:0] s1_op_q,    s1_op_d;
  logic [TAG_W-1:0]    s1_rd_q,    s1_rd_d;
  logic                s1_we_q,    s1_we_d;
  lanes_t              s1_res_q,   s1_res_d;
  lanes_t              s1_pp_ll_q, s1_pp_ll_d;
  lanes_hi_t           s1_pp_x_q,  s1_pp_x_d;

  // S2 registers
  logic                s2_valid_q,  s2_valid_d;
  logic [VEC_W-1:0]    s2_result_q, s2_result_d;
  logic [LANES-1:0]    s2_zero_q,   s2_zero_d;
  logic [TAG_W-1:0]    s2_rd_q,     s2_rd_d;
  logic                s2_we_q,     s2_we_d;

  // S1 -> S2 combinational completion
  lanes_t           s2_final;
  logic [LANES-1:0] s2_zero_vec;

  // Handshake
  logic s2_free;   // S2 is empty or hands its entry over this cycle
  logic in_fire;
  logic s1_move;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free || flush;
  assign in_fire  = in_valid && in_ready && !flush;
  assign s1_move  = s1_valid_q && s2_free && !flush;

  assign src_b_sel = in_bcast ? {LANES{in_scalar}} : in_src_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] mul_full;

    assign lane_a[i] = LANE_W'(lane_slice(MAX_VEC_W'(in_src_a), i, LANE_W));
    assign lane_b[i] = LANE_W'(lane_slice(MAX_VEC_W'(src_b_sel), i, LANE_W));

    vec_lane_alu #(
      .LANE_W (LANE_W)
    ) u_alu (
      .op_i    (in_op),
      .a_i     (lane_a[i]),
      .b_i     (lane_b[i]),
      .res_o   (alu_res[i]),
      .pp_ll_o (alu_pp_ll[i]),
      .pp_x_o  (alu_pp_x[i])
    );

    // Finish the multiply from the registered partial products.
    assign mul_full       = s1_pp_ll_q[i] + {s1_pp_x_q[i], {LO_W{1'b0}}};
    assign s2_final[i]    = (s1_op_q == OP_MUL) ? mul_full : s1_res_q[i];
    assign s2_zero_vec[i] = (s2_final[i] == '0);
  end

  // Next-state for both stages: flush wins over stall, stall holds everything.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_rd_d     = s1_rd_q;
    s1_we_d     = s1_we_q;
    s1_res_d    = s1_res_q;
    s1_pp_ll_d  = s1_pp_ll_q;
    s1_pp_x_d   = s1_pp_x_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_rd_d     = s2_rd_q;
    s2_we_d     = s2_we_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready) s1_valid_d = in_valid;
      if (s2_free)  s2_valid_d = s1_valid_q;
      if (in_fire) begin
        s1_op_d    = in_op;
        s1_rd_d    = in_rd;
        s1_we_d    = in_we;
        s1_res_d   = alu_res;
        s1_pp_ll_d = alu_pp_ll;
        s1_pp_x_d  = alu_pp_x;
      end
      if (s1_move) begin
        s2_result_d = s2_final;
        s2_zero_d   = s2_zero_vec;
        s2_rd_d     = s1_rd_q;
        s2_we_d     = s1_we_q;
      end
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset as well, since out_result/out_zero/out_rd/out_we must read 0 out of reset.
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_we_q     <= 1'b0;
      s1_res_q    <= '0;
      s1_pp_ll_q  <= '0;
      s1_pp_x_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= '0;
      s2_rd_q     <= '0;
      s2_we_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_we_q     <= s1_we_d;
      s1_res_q    <= s1_res_d;
      s1_pp_ll_q  <= s1_pp_ll_d;
      s1_pp_x_q   <= s1_pp_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_rd_q     <= s2_rd_d;
      s2_we_q     <= s2_we_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_rd     = s2_rd_q;
  assign out_we     = s2_we_q;

endmodule

// File: tb/tb_vec_exec_pipe.sv
// Self-checking bench for vec_exec_pipe (LANES=3, LANE_W=16, TAG_W=5).
// Expected results are pushed to a scoreboard when an input is accepted and
// compared when the DUT hands a result over.
module tb_vec_exec_pipe;
  import vec_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [47:0] in_src_a;
  logic [47:0] in_src_b;
  logic [15:0] in_scalar;
  logic        in_bcast;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_result;
  logic [2:0]  out_zero;
  logic [4:0]  out_rd;
  logic        out_we;

  vec_exec_pipe #(
    .LANES  (3),
    .LANE_W (16),
    .TAG_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src_a   (in_src_a),
    .in_src_b   (in_src_b),
    .in_scalar  (in_scalar),
    .in_bcast   (in_bcast),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .out_we     (out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] res;
    logic [2:0]  zero;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stream_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Independent reference for one 16-bit lane.
  function automatic logic [15:0] lane_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    int     sa, sb, r;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    case (op)
      4'd0:  r = int'(a) + int'(b);
      4'd1:  r = int'(a) - int'(b);
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = int'(a) << b[3:0];
      4'd6:  r = int'(a) >> b[3:0];
      4'd7:  r = sa >>> b[3:0];
      4'd8:  begin r = sa + sb; if (r > 32767) r = 32767; else if (r < -32768) r = -32768; end
      4'd9:  begin r = sa - sb; if (r > 32767) r = 32767; else if (r < -32768) r = -32768; end
      4'd10: r = (sa < sb) ? sa : sb;
      4'd11: r = (sa > sb) ? sa : sb;
      4'd12: begin p = longint'(a) * longint'(b); r = int'(p & 64'hFFFF); end
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] op, input logic [47:0] a, input logic [47:0] b,
                                  input logic [15:0] sc, input logic bc, input logic [4:0] rd,
                                  input logic we);
    exp_t        e;
    logic [15:0] bl, rl;
    e.res = '0;
    e.zero = '0;
    for (int i = 0; i < 3; i++) begin
      bl = bc ? sc : b[i*16 +: 16];
      rl = lane_model(op, a[i*16 +: 16], bl);
      e.res[i*16 +: 16] = rl;
      e.zero[i] = (rl == 16'h0);
    end
    e.rd = rd;
    e.we = we;
    return e;
  endfunction

  function automatic exp_t mk_const(input logic [47:0] res, input logic [2:0] zero,
                                    input logic [4:0] rd, input logic we);
    exp_t e;
    e.res = res; e.zero = zero; e.rd = rd; e.we = we;
    return e;
  endfunction

  // Drive one op (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [3:0] op, input logic [47:0] a, input logic [47:0] b,
                      input logic [15:0] sc, input logic bc, input logic [4:0] rd,
                      input logic we, input exp_t e);
    bit acc = 1'b0;
    in_op = op; in_src_a = a; in_src_b = b; in_scalar = sc;
    in_bcast = bc; in_rd = rd; in_we = we; in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (in_ready && rst) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: scoreboard compare on transfer, stability while stalled.
  initial begin
    bit          stall_prev;
    logic [47:0] held_res;
    logic [4:0]  held_rd;
    exp_t        e;
    stall_prev = 1'b0;
    held_res = '0;
    held_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          check("hold_result", 64'(out_result), 64'(held_res));
          check("hold_rd", 64'(out_rd), 64'(held_rd));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("result", 64'(out_result), 64'(e.res));
            check("zero", 64'(out_zero), 64'(e.zero));
            check("rd_we", 64'({out_rd, out_we}), 64'({e.rd, e.we}));
          end
        end
        stall_prev = out_valid && !out_ready;
        held_res = out_result;
        held_rd = out_rd;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_src_a = '0; in_src_b = '0;
    in_scalar = '0; in_bcast = 1'b0; in_rd = '0; in_we = 1'b0;
    flush = 1'b0; out_ready = 1'b1; stream_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_we", 64'(out_we), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ADD with latency check: accept at edge N, valid after edge N+1
    send(OP_ADD, 48'h0001_FFFF_7FFF, 48'h0001_0001_0001, 16'h0, 1'b0, 5'd7, 1'b1,
         mk_const(48'h0002_0000_8000, 3'b010, 5'd7, 1'b1));
    @(negedge clk);
    check("lat_edge_n", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge_n1", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    wait_drain();

    // Directed corner ops
    send(OP_ADDS, 48'h0001_FFFF_7FFF, 48'h0001_0001_0001, 16'h0, 1'b0, 5'd8, 1'b1,
         mk_const(48'h0002_0000_7FFF, 3'b010, 5'd8, 1'b1));
    send(OP_SUBS, 48'h8000_8000_8000, 48'h0001_0001_0001, 16'h0, 1'b0, 5'd9, 1'b0,
         mk_const(48'h8000_8000_8000, 3'b000, 5'd9, 1'b0));
    send(OP_MUL, 48'h0003_0100_FFFF, 48'h1234_5678_9ABC, 16'h0005, 1'b1, 5'd10, 1'b1,
         mk_const(48'h000F_0500_FFFB, 3'b000, 5'd10, 1'b1));
    send(OP_SRA, 48'h8000_7FF0_0010, 48'h0004_0004_0004, 16'h0, 1'b0, 5'd11, 1'b1,
         mk_const(48'hF800_07FF_0001, 3'b000, 5'd11, 1'b1));
    send(4'd14, 48'hAAAA_5555_FFFF, 48'h1111_2222_3333, 16'h0, 1'b0, 5'd12, 1'b1,
         mk_const(48'h0000_0000_0000, 3'b111, 5'd12, 1'b1));
    wait_drain();

    // Backpressure: 4 ADDs, out_ready low for 3 cycles after the first result
    fork
      begin
        for (int t = 1; t <= 4; t++) begin
          logic [47:0] a, b;
          a = {3{16'(t * 16'h0101)}};
          b = {16'h0001, 16'h0010, 16'h0100};
          send(OP_ADD, a, b, 16'h0, 1'b0, 5'(t), 1'b1,
               mk_exp(OP_ADD, a, b, 16'h0, 1'b0, 5'(t), 1'b1));
        end
      end
      begin
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = out_valid;
        end
        check("bp_first_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_valid_held", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_resume", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
      end
    join
    wait_drain();

    // Mixed stream with random backpressure
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [3:0]  op;
          logic [47:0] a, b;
          logic [15:0] sc;
          logic        bc, we;
          op = 4'($urandom_range(0, 15));
          a  = 48'({$urandom(), $urandom()});
          b  = 48'({$urandom(), $urandom()});
          sc = 16'($urandom());
          bc = 1'($urandom_range(0, 1));
          we = 1'($urandom_range(0, 1));
          if (k % 6 == 0) b = a;  // exercise zero results for SUB/XOR
          send(op, a, b, sc, bc, 5'(k), we, mk_exp(op, a, b, sc, bc, 5'(k), we));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          if (!stream_done) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with S1 and S2 full and a new input presented
    out_ready = 1'b0;
    send(OP_ADD, 48'h1, 48'h1, 16'h0, 1'b0, 5'd20, 1'b1, mk_const(48'h2, 3'b110, 5'd20, 1'b1));
    send(OP_ADD, 48'h2, 48'h2, 16'h0, 1'b0, 5'd21, 1'b1, mk_const(48'h4, 3'b110, 5'd21, 1'b1));
    flush = 1'b1;
    in_valid = 1'b1; in_op = OP_OR; in_src_a = 48'hFFFF; in_src_b = 48'h0; in_rd = 5'd22;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check("flush_no_valid_1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("flush_no_valid_2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(OP_XOR, 48'h00FF_F0F0_1234, 48'h00FF_0F0F_1234, 16'h0, 1'b0, 5'd23, 1'b1,
         mk_const(48'h0000_FFFF_0000, 3'b101, 5'd23, 1'b1));
    wait_drain();

    // Asynchronous reset mid-stream
    send(OP_OR, 48'h1234_5678_9ABC, 48'h0, 16'h0, 1'b0, 5'd24, 1'b1,
         mk_const(48'h1234_5678_9ABC, 3'b000, 5'd24, 1'b1));
    send(OP_OR, 48'h1111_2222_3333, 48'h0, 16'h0, 1'b0, 5'd25, 1'b1,
         mk_const(48'h1111_2222_3333, 3'b000, 5'd25, 1'b1));
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_we", 64'(out_we), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_we", 64'(out_we), 64'd0);
    check("async_rst_result", 64'(out_result), 64'd0);
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(OP_MAX, 48'h8000_0005_FFFF, 48'h7FFF_0003_0001, 16'h0, 1'b0, 5'd26, 1'b0,
         mk_const(48'h7FFF_0005_0001, 3'b000, 5'd26, 1'b0));
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
